// File: rtl/bike_pkg.sv
// Shared definitions for the bike-computer speed pipeline: FSM encoding,
// wheel/timing defaults and the speed LSB unit used by downstream stages.
package bike_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } spd_state_e;

  // 2100 mm circumference * 36 -> speed[0.1 km/h] = K / period_ms
  localparam int unsigned K_DEFAULT        = 75600;
  localparam int unsigned DEBOUNCE_DEFAULT = 20;
  localparam int unsigned TIMEOUT_DEFAULT  = 3000;

  // One speed LSB is 0.1 km/h, i.e. 100 m/h.
  localparam int unsigned SPEED_LSB_M_PER_H = 100;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per clock, NUM_WIDTH cycles
// from start to a one-cycle done pulse. Quotient is valid while done is high.
module seq_divider #(
  parameter int NUM_WIDTH = 20,
  parameter int DEN_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] num,
  input  logic [DEN_WIDTH-1:0] den,
  output logic [NUM_WIDTH-1:0] quot,
  output logic                 done,
  output logic                 busy
);

  localparam int CW = $clog2(NUM_WIDTH + 1);

  logic [NUM_WIDTH:0]   rem_q, rem_d;
  logic [NUM_WIDTH-1:0] quot_q, quot_d;
  logic [NUM_WIDTH-1:0] den_q, den_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_WIDTH:0]   shifted;
  logic [NUM_WIDTH:0]   diff;

  // quot_q starts holding the dividend; its MSB feeds the remainder while
  // quotient bits shift in from the bottom.
  always_comb begin
    rem_d   = rem_q;
    quot_d  = quot_q;
    den_d   = den_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    shifted = {rem_q[NUM_WIDTH-1:0], quot_q[NUM_WIDTH-1]};
    diff    = shifted - {1'b0, den_q};
    if (start) begin
      rem_d  = '0;
      quot_d = num;
      den_d  = NUM_WIDTH'(den);
      cnt_d  = CW'(NUM_WIDTH);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (shifted >= {1'b0, den_q}) begin
        rem_d  = diff;
        quot_d = {quot_q[NUM_WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = shifted;
        quot_d = {quot_q[NUM_WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      rem_q  <= '0;
      quot_q <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      den_q  <= den_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quot = quot_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: rtl/speed_calc.sv
// Wheel speed front end: times reed-pulse periods in ms ticks and divides
// K by the period to produce speed in 0.1 km/h, with stop detection.
module speed_calc
  import bike_pkg::*;
#(
  parameter int          WIDTH     = 12,
  parameter int          CNT_WIDTH = 12,
  parameter int          NUM_WIDTH = 20,
  parameter int unsigned K         = K_DEFAULT,
  parameter int unsigned DEBOUNCE  = DEBOUNCE_DEFAULT,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             r,
  input  logic             tick,
  input  logic             reed,
  output logic [WIDTH-1:0] speed,
  output logic             speed_valid,
  output logic             moving
);

  localparam logic [CNT_WIDTH-1:0] DEB_C  = CNT_WIDTH'(DEBOUNCE);
  localparam logic [CNT_WIDTH-1:0] TOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [NUM_WIDTH-1:0] NUM_C  = NUM_WIDTH'(K);
  localparam logic [NUM_WIDTH-1:0] SAT_C  = NUM_WIDTH'((64'd1 << WIDTH) - 64'd1);

  spd_state_e           state_q, state_d;
  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 sync3_q, sync3_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0]     speed_q, speed_d;
  logic                 valid_q, valid_d;
  logic                 moving_q, moving_d;
  logic                 start_q, start_d;
  logic                 reed_rise;
  logic [NUM_WIDTH-1:0] div_quot;
  logic                 div_done;
  logic                 div_busy;

  assign reed_rise = sync2_q & ~sync3_q;

  always_comb begin
    sync1_d  = reed;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    cnt_d    = (tick && (cnt_q < TOUT_C)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    state_d  = state_q;
    period_d = period_q;
    speed_d  = speed_q;
    valid_d  = 1'b0;
    start_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reed_rise) begin
          cnt_d   = '0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        // A valid edge takes priority over the timeout landing in the same cycle.
        if (reed_rise && (cnt_q >= DEB_C)) begin
          period_d = cnt_q;
          cnt_d    = '0;
          start_d  = 1'b1;
          state_d  = DIVIDE;
        end else if (cnt_q == TOUT_C) begin
          speed_d = '0;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      DIVIDE: begin
        if (div_done) begin
          speed_d = (div_quot > SAT_C) ? '1 : div_quot[WIDTH-1:0];
          valid_d = 1'b1;
          state_d = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase
    moving_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      sync3_q  <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      speed_q  <= '0;
      valid_q  <= 1'b0;
      moving_q <= 1'b0;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      sync3_q  <= sync3_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      speed_q  <= speed_d;
      valid_q  <= valid_d;
      moving_q <= moving_d;
      start_q  <= start_d;
    end
  end

  seq_divider #(
    .NUM_WIDTH(NUM_WIDTH),
    .DEN_WIDTH(CNT_WIDTH)
  ) u_div (
    .clk  (clk),
    .r    (r),
    .start(start_q),
    .num  (NUM_C),
    .den  (period_q),
    .quot (div_quot),
    .done (div_done),
    .busy (div_busy)
  );

  assign speed       = speed_q;
  assign speed_valid = valid_q;
  assign moving      = moving_q;

endmodule

// File: tb/tb_speed_calc.sv
// Directed bench for speed_calc: periods, debounce, stop timeout, saturation
// (second instance with K=100000), reset mid-divide and tick/edge collision.
module tb_speed_calc;

  logic        clk = 1'b0;
  logic        r = 1'b0;
  logic        tick = 1'b0;
  logic        reed = 1'b0;
  logic [11:0] speed, speed2;
  logic        speed_valid, valid2;
  logic        moving, moving2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  speed_calc dut (
    .clk(clk), .r(r), .tick(tick), .reed(reed),
    .speed(speed), .speed_valid(speed_valid), .moving(moving)
  );

  speed_calc #(.K(100000)) dut_sat (
    .clk(clk), .r(r), .tick(tick), .reed(reed),
    .speed(speed2), .speed_valid(valid2), .moving(moving2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_ticks(input int n, output int np);
    np = 0;
    repeat (n) begin
      tick = 1'b1;
      step();
      if (speed_valid) np++;
      tick = 1'b0;
      step();
      if (speed_valid) np++;
    end
  endtask

  // Posedge index k after raising reed is E_k; E0 is the first sample of reed=1.
  task automatic pulse(input bit tick_e2, output int lat, output int np);
    lat  = -1;
    np   = 0;
    reed = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (tick_e2) tick = (k == 2);
      step();
      if (k == 4) reed = 1'b0;
      if (speed_valid) begin
        np++;
        if (lat < 0) lat = k;
      end
    end
    tick = 1'b0;
  endtask

  task automatic test_reset();
    r = 1'b0;
    repeat (3) step();
    checks++; if (speed !== 12'd0) begin errors++; $display("FAIL reset_speed: got %0d expected 0", speed); end
    checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", speed_valid); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving: got %b expected 0", moving); end
    r = 1'b1;
    step();
  endtask

  task automatic test_steady();
    int lat, np;
    pulse(1'b0, lat, np);
    checks++; if (np !== 0) begin errors++; $display("FAIL steady_first_edge: got %0d pulses expected 0", np); end
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL steady_moving0: got %b expected 1", moving); end
    for (int i = 0; i < 2; i++) begin
      run_ticks(500, np);
      checks++; if (np !== 0) begin errors++; $display("FAIL steady_quiet: got %0d pulses expected 0", np); end
      pulse(1'b0, lat, np);
      checks++; if (np !== 1) begin errors++; $display("FAIL steady_npulse: got %0d expected 1", np); end
      checks++; if (lat !== 24) begin errors++; $display("FAIL steady_latency: got %0d expected 24", lat); end
      checks++; if (speed !== 12'd151) begin errors++; $display("FAIL steady_speed: got %0d expected 151", speed); end
      checks++; if (moving !== 1'b1) begin errors++; $display("FAIL steady_moving: got %b expected 1", moving); end
    end
  endtask

  task automatic test_fast();
    int lat, np;
    run_ticks(20, np);
    pulse(1'b0, lat, np);
    checks++; if (speed !== 12'd3780) begin errors++; $display("FAIL fast_speed: got %0d expected 3780", speed); end
    checks++; if (speed2 !== 12'd4095) begin errors++; $display("FAIL sat_speed: got %0d expected 4095", speed2); end
    run_ticks(10, np);
    pulse(1'b0, lat, np);
    checks++; if (np !== 0) begin errors++; $display("FAIL glitch_ignored: got %0d pulses expected 0", np); end
    run_ticks(10, np);
    pulse(1'b0, lat, np);
    checks++; if (np !== 1) begin errors++; $display("FAIL glitch_next_npulse: got %0d expected 1", np); end
    checks++; if (speed !== 12'd3780) begin errors++; $display("FAIL glitch_next_speed: got %0d expected 3780", speed); end
    checks++; if (speed2 !== 12'd4095) begin errors++; $display("FAIL glitch_next_sat: got %0d expected 4095", speed2); end
  endtask

  task automatic test_stop();
    int lat, np;
    run_ticks(2999, np);
    checks++; if (np !== 0) begin errors++; $display("FAIL stop_early: got %0d pulses expected 0", np); end
    checks++; if (moving !== 1'b1) begin errors++; $display("FAIL stop_early_moving: got %b expected 1", moving); end
    run_ticks(1, np);
    checks++; if (np !== 1) begin errors++; $display("FAIL stop_npulse: got %0d expected 1", np); end
    checks++; if (speed !== 12'd0) begin errors++; $display("FAIL stop_speed: got %0d expected 0", speed); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL stop_moving: got %b expected 0", moving); end
    pulse(1'b0, lat, np);
    checks++; if (np !== 0) begin errors++; $display("FAIL restart_first: got %0d pulses expected 0", np); end
    run_ticks(500, np);
    pulse(1'b0, lat, np);
    checks++; if (speed !== 12'd151) begin errors++; $display("FAIL restart_speed: got %0d expected 151", speed); end
    checks++; if (lat !== 24) begin errors++; $display("FAIL restart_latency: got %0d expected 24", lat); end
  endtask

  task automatic test_reset_mid_divide();
    int lat, np;
    run_ticks(500, np);
    reed = 1'b1;
    np = 0;
    for (int k = 0; k < 9; k++) begin
      step();
      if (k == 4) reed = 1'b0;
      if (speed_valid) np++;
    end
    r = 1'b0;
    #1;
    checks++; if (speed !== 12'd0) begin errors++; $display("FAIL abort_speed: got %0d expected 0", speed); end
    checks++; if (moving !== 1'b0) begin errors++; $display("FAIL abort_moving: got %b expected 0", moving); end
    repeat (5) begin
      step();
      if (speed_valid) np++;
    end
    checks++; if (np !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", np); end
    r = 1'b1;
    step();
    pulse(1'b0, lat, np);
    checks++; if (np !== 0) begin errors++; $display("FAIL abort_first_edge: got %0d pulses expected 0", np); end
    run_ticks(500, np);
    pulse(1'b0, lat, np);
    checks++; if (speed !== 12'd151) begin errors++; $display("FAIL abort_recover_speed: got %0d expected 151", speed); end
  endtask

  task automatic test_tick_edge();
    int lat, np;
    run_ticks(499, np);
    pulse(1'b1, lat, np);
    checks++; if (np !== 1) begin errors++; $display("FAIL tick_edge_npulse: got %0d expected 1", np); end
    checks++; if (speed !== 12'd151) begin errors++; $display("FAIL tick_edge_speed: got %0d expected 151", speed); end
    checks++; if (lat !== 24) begin errors++; $display("FAIL tick_edge_latency: got %0d expected 24", lat); end
    // The colliding tick must be dropped by the clear, so the next period is exactly 20.
    run_ticks(20, np);
    pulse(1'b0, lat, np);
    checks++; if (speed !== 12'd3780) begin errors++; $display("FAIL tick_edge_clear: got %0d expected 3780", speed); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_fast();
    test_stop();
    test_reset_mid_divide();
    test_tick_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speed_calc.md
Name: speed_calc

Overview:
- Upstream stage of the bike-computer max-speed tracker. Measures the time between wheel-sensor (reed) pulses and converts it into the current speed.
- Speed is in 0.1 km/h units, computed as speed = K / period with a sequential divider.
- Output drives the max-speed and display stages, which take a WIDTH-bit speed bus.

Parameters:
WIDTH, 12, speed output width; result saturates at 2^WIDTH-1
CNT_WIDTH, 12, period counter width in ms ticks
NUM_WIDTH, 20, dividend width for the divider
K, 75600, circumference_mm*36 (2100 mm wheel) -> speed[0.1 km/h] = K/period_ms
DEBOUNCE, 20, minimum accepted period in ticks; shorter edges are ignored
TIMEOUT, 3000, period in ticks at which the wheel is declared stopped

Ports:
clk  in  1  system clock
r  in  1  reset, asynchronous, active-low (0 = reset)
tick  in  1  one-cycle enable at 1 kHz from the shared prescaler
reed  in  1  raw wheel sensor, asynchronous to clk
speed  out  WIDTH  current speed, 0.1 km/h units
speed_valid  out  1  one-cycle pulse when speed is updated
moving  out  1  high while a period measurement is active

Behaviour:
- Reset (r=0, async): speed=0, speed_valid=0, moving=0, FSM=IDLE, period counter=0, sync flops=0, divider aborted.
- Input conditioning:
  - reed passes through a 2-flop synchroniser, then a rising-edge detect register.
  - edge = sync2 & ~sync3, one cycle wide.
- Period counter:
  - increments on tick; saturates at TIMEOUT.
  - cleared on every accepted edge.
- FSM states: IDLE, MEASURE, DIVIDE.
  - IDLE: moving=0. Edge -> clear counter, go to MEASURE. No speed output on the first edge.
  - MEASURE: moving=1.
    - Edge with counter < DEBOUNCE: ignored; counter keeps running.
    - Edge with counter >= DEBOUNCE: latch counter as period, clear counter, start divider, go to DIVIDE.
    - Counter == TIMEOUT (no edge): speed<=0, speed_valid pulse, go to IDLE.
    - Edge and timeout reached in the same cycle: the edge wins (period = TIMEOUT is processed).
  - DIVIDE: moving=1.
    - Counter keeps counting ticks.
    - Edges are ignored; DEBOUNCE ms is far longer than the divider latency.
    - On divider done: speed <= min(quotient, 2^WIDTH-1), speed_valid pulse, go to MEASURE.
- Divider: restoring, one quotient bit per clk, NUM_WIDTH cycles. Numerator is K; denominator is the period zero-extended to NUM_WIDTH. The period is never 0, because DEBOUNCE >= 1 is enforced by the FSM.
- Latency: speed_valid rises exactly NUM_WIDTH+4 clk cycles after the first clk edge that samples reed=1. Breakdown: 2 sync cycles, 1 edge detect, 1 start, NUM_WIDTH divide.
- speed holds its value between updates. speed_valid is high for exactly one cycle per update.
- Reset asserted mid-DIVIDE: immediate abort, all outputs 0, no speed_valid pulse.
- tick and reed edge in the same cycle: the edge latches the pre-increment count, then the counter clears.

Decomposition:
- Package bike_pkg holds:
  - FSM state enum (IDLE/MEASURE/DIVIDE)
  - default K, DEBOUNCE, TIMEOUT constants
  - speed unit constant (0.1 km/h), shared with the max-speed and display stages
- Sub-module seq_divider, parameters NUM_WIDTH and DEN_WIDTH.
  - Inputs: clk, r, start, num, den.
  - Outputs: quot, done (one-cycle pulse), busy.
  - Reusable by the average-speed block.

Test Plan:
- Reset then steady pedalling: edges 500 ticks apart -> first edge gives no output; each later edge gives speed=151, speed_valid pulse at exactly 24 clk after edge sampling, moving=1.
- Fast wheel: edges 20 ticks apart -> speed=3780. Insert a glitch edge 10 ticks after an accepted edge -> ignored, next update still uses the 20-tick period, speed=3780.
- Stop: last edge followed by no edges -> after 3000 ticks speed=0, one speed_valid pulse, moving=0, FSM in IDLE. The next edge produces no output; the following edge produces a speed.
- Saturation with K=100000 override: period 20 -> quotient 5000 -> speed=4095.
- Reset mid-divide: r low 5 cycles after the divider starts -> speed=0 immediately, no speed_valid pulse. After release, the first edge gives no output and the second edge (period 500) gives speed=151.
- Simultaneous tick and edge at count 499 -> period latched as 499, speed=151 (75600/499=151).
